// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 245-synchronous FIFO device model.
package ft600_pkg;

  localparam int unsigned FT600_WIDTH = 16;

  typedef logic [FT600_WIDTH-1:0] ft600_word_t;

  typedef struct packed {
    logic underrun;
    logic overrun;
    logic contention;
  } ft600_err_t;

endpackage

// File: rtl/ft600_fifo.sv
// Synchronous show-ahead FIFO with a registered head word and occupancy count.
module ft600_fifo
  import ft600_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = FT600_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_inc;
  logic [DEPTH_LOG2:0]   count_next;
  logic [WIDTH-1:0]      head_next;
  logic                  push_ok;
  logic                  pop_ok;

  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign pop_ok     = pop && !empty;
  // A push into a full FIFO is legal when a pop frees the head slot on the same edge.
  assign push_ok    = push && (!full || pop_ok);
  assign rd_ptr_inc = rd_ptr + 1'b1;

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Head follows the next entry after a pop; popping the last entry keeps the old word.
  always_comb begin
    head_next = head;
    if (pop_ok) begin
      if (count == CNT_ONE) begin
        if (push_ok) head_next = push_data;
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end else if (push_ok && empty) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr_inc;
      count <= count_next;
      head  <= head_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft600_responder.sv
// Device-side FT600 245-sync FIFO bus model: RX FIFO feeds master reads,
// master writes fill the TX FIFO; usb_ad is split into in/out/enable.
module ft600_responder
  import ft600_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = FT600_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             usb_rd_n,
  input  logic             usb_oe_n,
  input  logic             usb_wr_n,
  input  logic [WIDTH-1:0] usb_ad_in,
  output logic             usb_rxf,
  output logic             usb_txe,
  output logic [WIDTH-1:0] usb_ad_out,
  output logic             usb_ad_oe,
  input  logic             rx_push_valid,
  input  logic [WIDTH-1:0] rx_push_data,
  output logic             rx_push_ready,
  output logic             tx_pop_valid,
  output logic [WIDTH-1:0] tx_pop_data,
  input  logic             tx_pop_ready,
  output logic             err_underrun,
  output logic             err_overrun,
  output logic             err_contention
);

  localparam logic [DEPTH_LOG2:0] CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] CNT_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ALMOST = CNT_FULL - CNT_ONE;

  logic                rd_req;
  logic                rd_fire;
  logic                wr_req;
  logic                wr_fire;
  logic                rx_push_fire;
  logic                tx_pop_fire;
  logic                rx_full;
  logic                rx_empty;
  logic                tx_full;
  logic                tx_empty;
  logic [DEPTH_LOG2:0] rx_count;
  logic [DEPTH_LOG2:0] tx_count;
  logic [WIDTH-1:0]    rx_head;
  logic [WIDTH-1:0]    tx_head;
  logic                rxf_q;
  logic                txe_q;
  logic                rxf_d;
  logic                txe_d;
  logic                ad_oe_q;
  ft600_err_t          err_q;
  ft600_err_t          err_d;

  assign rd_req       = !usb_rd_n && !usb_oe_n;
  assign rd_fire      = rd_req && !rxf_q;
  assign wr_req       = !usb_wr_n;
  assign rx_push_fire = rx_push_valid && rx_push_ready;
  assign tx_pop_fire  = tx_pop_valid && tx_pop_ready;
  // txe is high only when full; a same-edge local pop still lets the write through.
  assign wr_fire      = wr_req && usb_oe_n && (!txe_q || tx_pop_fire);

  ft600_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_rx_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (rx_push_fire),
    .push_data (rx_push_data),
    .pop       (rd_fire),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  ft600_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_tx_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (wr_fire),
    .push_data (usb_ad_in),
    .pop       (tx_pop_fire),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign rx_push_ready = !rx_full;
  assign tx_pop_valid  = !tx_empty;
  assign tx_pop_data   = tx_head;
  assign usb_ad_out    = rx_head;
  assign usb_rxf       = rxf_q;
  assign usb_txe       = txe_q;
  assign usb_ad_oe     = ad_oe_q;
  assign err_underrun   = err_q.underrun;
  assign err_overrun    = err_q.overrun;
  assign err_contention = err_q.contention;

  // Flags reflect the post-edge occupancy, derived from current count and this edge's traffic.
  always_comb begin
    rxf_d = 1'b0;
    txe_d = 1'b0;
    if (rx_empty) rxf_d = !rx_push_fire;
    else          rxf_d = (rx_count == CNT_ONE) && rd_fire && !rx_push_fire;
    if (tx_full)  txe_d = !(tx_pop_fire && !wr_fire);
    else          txe_d = (tx_count == CNT_ALMOST) && wr_fire && !tx_pop_fire;
  end

  always_comb begin
    err_d = err_q;
    if (rd_req && rxf_q)                          err_d.underrun   = 1'b1;
    if (wr_req && !usb_oe_n)                      err_d.contention = 1'b1;
    if (wr_req && usb_oe_n && txe_q && !tx_pop_fire) err_d.overrun = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxf_q   <= 1'b1;
      txe_q   <= 1'b1;
      ad_oe_q <= 1'b0;
      err_q   <= '0;
    end else begin
      rxf_q   <= rxf_d;
      txe_q   <= txe_d;
      ad_oe_q <= !usb_oe_n;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ft600_responder.sv
// Scoreboard bench for ft600_responder: queue-based reference model, directed
// scenarios followed by randomized bus and local-port traffic.
module tb_ft600_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        usb_rd_n = 1'b1;
  logic        usb_oe_n = 1'b1;
  logic        usb_wr_n = 1'b1;
  logic [15:0] usb_ad_in = '0;
  logic        usb_rxf;
  logic        usb_txe;
  logic [15:0] usb_ad_out;
  logic        usb_ad_oe;
  logic        rx_push_valid = 1'b0;
  logic [15:0] rx_push_data = '0;
  logic        rx_push_ready;
  logic        tx_pop_valid;
  logic [15:0] tx_pop_data;
  logic        tx_pop_ready = 1'b0;
  logic        err_underrun;
  logic        err_overrun;
  logic        err_contention;

  always #5 CLK = ~CLK;

  ft600_responder #(
    .DEPTH_LOG2 (4),
    .WIDTH      (16)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .usb_rd_n       (usb_rd_n),
    .usb_oe_n       (usb_oe_n),
    .usb_wr_n       (usb_wr_n),
    .usb_ad_in      (usb_ad_in),
    .usb_rxf        (usb_rxf),
    .usb_txe        (usb_txe),
    .usb_ad_out     (usb_ad_out),
    .usb_ad_oe      (usb_ad_oe),
    .rx_push_valid  (rx_push_valid),
    .rx_push_data   (rx_push_data),
    .rx_push_ready  (rx_push_ready),
    .tx_pop_valid   (tx_pop_valid),
    .tx_pop_data    (tx_pop_data),
    .tx_pop_ready   (tx_pop_ready),
    .err_underrun   (err_underrun),
    .err_overrun    (err_overrun),
    .err_contention (err_contention)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy counts, registered flags and sticky errors,
  // plus the expected data streams for each direction.
  localparam int DEPTH = 16;
  int          m_rx_cnt = 0;
  int          m_tx_cnt = 0;
  bit          m_rxf = 1'b1;
  bit          m_txe = 1'b1;
  bit          m_adoe = 1'b0;
  bit          m_und = 1'b0;
  bit          m_ovr = 1'b0;
  bit          m_con = 1'b0;
  bit          started = 1'b0;
  logic [15:0] rx_exp[$];
  logic [15:0] tx_exp[$];
  bit          rd_ok, rpush, tpop, wr_ok;

  always @(posedge CLK) begin
    started = 1'b1;
    if (RST) begin
      m_rx_cnt = 0;
      m_tx_cnt = 0;
      m_rxf = 1'b1;
      m_txe = 1'b1;
      m_adoe = 1'b0;
      m_und = 1'b0;
      m_ovr = 1'b0;
      m_con = 1'b0;
      rx_exp.delete();
      tx_exp.delete();
    end else begin
      rd_ok = !usb_rd_n && !usb_oe_n && !m_rxf;
      if (!usb_rd_n && !usb_oe_n && m_rxf) m_und = 1'b1;
      rpush = rx_push_valid && (m_rx_cnt < DEPTH);
      tpop  = tx_pop_ready && (m_tx_cnt > 0);
      wr_ok = 1'b0;
      if (!usb_wr_n && !usb_oe_n)  m_con = 1'b1;
      else if (!usb_wr_n) begin
        if (!m_txe || tpop) wr_ok = 1'b1;
        else                m_ovr = 1'b1;
      end
      if (rpush) rx_exp.push_back(rx_push_data);
      if (wr_ok) tx_exp.push_back(usb_ad_in);
      m_rx_cnt = m_rx_cnt + int'(rpush) - int'(rd_ok);
      m_tx_cnt = m_tx_cnt + int'(wr_ok) - int'(tpop);
      m_rxf  = (m_rx_cnt == 0);
      m_txe  = (m_tx_cnt == DEPTH);
      m_adoe = !usb_oe_n;
    end
  end

  logic [15:0] exp_w;

  // Monitor: compares status every cycle and pops the scoreboard on each transfer.
  always @(negedge CLK) begin
    if (started) begin
      check_bit("usb_rxf", usb_rxf, m_rxf);
      check_bit("usb_txe", usb_txe, m_txe);
      check_bit("usb_ad_oe", usb_ad_oe, m_adoe);
      check_bit("rx_push_ready", rx_push_ready, m_rx_cnt < DEPTH);
      check_bit("tx_pop_valid", tx_pop_valid, m_tx_cnt > 0);
      check_bit("err_underrun", err_underrun, m_und);
      check_bit("err_overrun", err_overrun, m_ovr);
      check_bit("err_contention", err_contention, m_con);
      if (!RST && !usb_rd_n && !usb_oe_n && !usb_rxf) begin
        if (rx_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_read: bus read accepted, got %h expected no word", usb_ad_out);
        end else begin
          exp_w = rx_exp.pop_front();
          check_word("rx_read_data", usb_ad_out, exp_w);
        end
      end
      if (!RST && tx_pop_valid && tx_pop_ready) begin
        if (tx_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_pop: pop accepted, got %h expected no word", tx_pop_data);
        end else begin
          exp_w = tx_exp.pop_front();
          check_word("tx_pop_data", tx_pop_data, exp_w);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    usb_rd_n = 1'b1;
    usb_oe_n = 1'b1;
    usb_wr_n = 1'b1;
    rx_push_valid = 1'b0;
    tx_pop_ready = 1'b0;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    cyc();
    check_bit("rst_rxf", usb_rxf, 1'b1);
    check_bit("rst_txe", usb_txe, 1'b1);
    check_bit("rst_ad_oe", usb_ad_oe, 1'b0);
    check_word("rst_ad_out", usb_ad_out, 16'h0000);
    check_bit("rst_push_ready", rx_push_ready, 1'b1);
    check_bit("rst_pop_valid", tx_pop_valid, 1'b0);
    cyc();
    RST = 1'b0;
    cyc();
    check_bit("post_rst_txe", usb_txe, 1'b0);

    // Basic read then one read past empty
    rx_push_valid = 1'b1;
    rx_push_data = 16'h1111; cyc();
    rx_push_data = 16'h2222; cyc();
    rx_push_data = 16'h3333; cyc();
    rx_push_valid = 1'b0;
    usb_oe_n = 1'b0; cyc();
    usb_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check_bit("read_rxf_rise", usb_rxf, 1'b1);
    check_bit("read_no_underrun", err_underrun, 1'b0);
    cyc();
    usb_rd_n = 1'b1;
    usb_oe_n = 1'b1;
    check_bit("underrun_set", err_underrun, 1'b1);
    check_word("underrun_ad_out_held", usb_ad_out, 16'h3333);

    // Write to full: 17 writes, the last one overruns
    for (int i = 0; i <= 16; i++) begin
      usb_wr_n = 1'b0;
      usb_ad_in = 16'(i);
      cyc();
    end
    usb_wr_n = 1'b1;
    check_bit("full_txe", usb_txe, 1'b1);
    check_bit("full_overrun", err_overrun, 1'b1);

    // Flow-through on a full TX FIFO
    tx_pop_ready = 1'b1;
    usb_wr_n = 1'b0;
    usb_ad_in = 16'hABCD;
    cyc();
    tx_pop_ready = 1'b0;
    usb_wr_n = 1'b1;
    check_bit("flow_txe_still_full", usb_txe, 1'b1);
    check_bit("flow_no_contention", err_contention, 1'b0);
    tx_pop_ready = 1'b1;
    for (int i = 0; i < 16; i++) cyc();
    tx_pop_ready = 1'b0;
    check_bit("drained_pop_valid", tx_pop_valid, 1'b0);

    // Contention: write dropped, TX stays empty
    usb_wr_n = 1'b0;
    usb_oe_n = 1'b0;
    usb_ad_in = 16'h5555;
    cyc();
    idle();
    check_bit("contention_set", err_contention, 1'b1);
    check_bit("contention_tx_empty", tx_pop_valid, 1'b0);

    // Reset in the middle of a read stream
    rx_push_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_push_data = 16'h8000 + 16'(i);
      cyc();
    end
    rx_push_valid = 1'b0;
    usb_oe_n = 1'b0; cyc();
    usb_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    RST = 1'b1;
    cyc();
    check_bit("midrst_rxf", usb_rxf, 1'b1);
    check_bit("midrst_txe", usb_txe, 1'b1);
    check_bit("midrst_ad_oe", usb_ad_oe, 1'b0);
    check_bit("midrst_underrun", err_underrun, 1'b0);
    check_bit("midrst_overrun", err_overrun, 1'b0);
    check_bit("midrst_contention", err_contention, 1'b0);
    RST = 1'b0;
    idle();
    cyc();
    check_bit("midrst_release_txe", usb_txe, 1'b0);

    // Random traffic: alternate fill-heavy and drain-heavy segments
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 400; c++) begin
        if (seg % 2 == 0) begin
          rx_push_valid = ($urandom_range(0, 7) != 0);
          usb_rd_n      = ($urandom_range(0, 3) != 0);
          usb_wr_n      = ($urandom_range(0, 7) == 0);
          tx_pop_ready  = ($urandom_range(0, 3) == 0);
        end else begin
          rx_push_valid = ($urandom_range(0, 3) == 0);
          usb_rd_n      = ($urandom_range(0, 7) == 0);
          usb_wr_n      = ($urandom_range(0, 3) != 0);
          tx_pop_ready  = ($urandom_range(0, 7) != 0);
        end
        usb_oe_n     = ($urandom_range(0, 2) == 0);
        rx_push_data = 16'($urandom);
        usb_ad_in    = 16'($urandom);
        cyc();
      end
    end
    idle();
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ft600_responder.md
# ft600_responder

Synthesizable device-side model of the FT600 245-synchronous FIFO bus: it plays the FT600 chip against our FPGA-side bridge in simulation and in loopback builds. Two internal FIFOs are used. The RX FIFO is loaded from a local push port and drained by the master's reads. The TX FIFO is filled by the master's writes and drained by a local pop port. The bidirectional `usb_ad` bus is split into in/out/enable; the top level owns the tristate.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4. Log2 of the entry count of each FIFO (16 entries).
- `WIDTH`, default 16. Bus word width; only 16 is supported.

Ports:
- `CLK` input, 1 bit. Bus clock; the block has one clock.
- `RST` input, 1 bit. Reset is synchronous and active-high.
- `usb_rd_n` input, 1 bit. Master read strobe, active-low.
- `usb_oe_n` input, 1 bit. Master output-enable request, active-low.
- `usb_wr_n` input, 1 bit. Master write strobe, active-low.
- `usb_ad_in` input, WIDTH. Bus value driven by the master.
- `usb_rxf` output, 1 bit. Active-low; 0 means read data is available.
- `usb_txe` output, 1 bit. Active-low; 0 means write space is available.
- `usb_ad_out` output, WIDTH. Data driven by the device.
- `usb_ad_oe` output, 1 bit. 1 means the device drives the bus.
- `rx_push_valid` / `rx_push_data[WIDTH]` input, `rx_push_ready` output. Valid/ready port that loads the RX FIFO.
- `tx_pop_valid` / `tx_pop_data[WIDTH]` output, `tx_pop_ready` input. Valid/ready port that drains the TX FIFO.
- `err_underrun`, `err_overrun`, `err_contention` outputs, 1 bit each. Sticky error flags, cleared only by `RST`.

## Operation
- Read accept: on a rising edge with `usb_oe_n`=0, `usb_rd_n`=0 and the registered `usb_rxf`=0, the block pops the RX head.
- Read underrun: a read strobe (`usb_rd_n`=0, `usb_oe_n`=0) while `usb_rxf`=1 pops nothing and sets `err_underrun`.
- Write accept: on an edge with `usb_wr_n`=0 and `usb_txe`=0, the block pushes `usb_ad_in` into the TX FIFO.
- Write overrun: `usb_wr_n`=0 while `usb_txe`=1 is dropped and sets `err_overrun`.
- Contention: `usb_wr_n`=0 and `usb_oe_n`=0 on the same edge drops the write and sets `err_contention`. A read on that edge still proceeds.
- Local push: an RX push is accepted when `rx_push_valid` and `rx_push_ready` are both high.
- Local pop: a TX pop is accepted when `tx_pop_valid` and `tx_pop_ready` are both high.
- Simultaneous push and pop on the same FIFO leave its count unchanged. This holds when full; empty is covered by valid being low.
- Counts span 0..2^DEPTH_LOG2 (DEPTH_LOG2+1 bits). Pointers wrap modulo depth.

## Timing
- Reset values:
  - `usb_rxf`=1, `usb_txe`=1.
  - `usb_ad_oe`=0, `usb_ad_out`=0.
  - `tx_pop_valid`=0, `rx_push_ready`=1.
  - All `err_*`=0, both FIFOs empty.
- Reset asserted mid-transfer discards all FIFO contents at that edge.
- `usb_rxf` and `usb_txe` are registered:
  - `usb_rxf` next = (RX count_next == 0).
  - `usb_txe` next = (TX count_next == DEPTH).
  - After reset release, `usb_txe` falls one cycle later.
  - On the edge that pops the last RX word, `usb_rxf` rises in the same edge; the master sees it one cycle later.
- `usb_ad_oe` is registered and equals `usb_oe_n` inverted with 1-cycle latency. This models FT600 bus turnaround.
- `usb_ad_out` is registered. It holds the RX head (show-ahead) and updates the cycle after a pop or after a push into an empty FIFO. It is valid while `usb_ad_oe`=1.
- Throughput: one word per cycle in each direction. Back-to-back reads with `usb_rd_n` held low stream consecutive entries.
- Local ports are combinational from FIFO state:
  - `rx_push_ready` = not full.
  - `tx_pop_valid` = not empty.
  - `tx_pop_data` = TX head.
  - A pushed word is visible on `tx_pop_*` the next cycle.

## Structure
- Package `ft600_pkg` holds:
  - constant `FT600_WIDTH`=16;
  - typedef `ft600_word_t`;
  - typedef for the error-flag bundle.
- Sub-module `ft600_fifo` (sync FIFO, show-ahead, registered head, count output) is instanced twice, once for RX and once for TX.
- The top level contains the strobe decode, the registered flag logic and the error flags.

## Test plan
- Basic read: push 0x1111, 0x2222, 0x3333 locally, then drive `usb_oe_n`=0 for 1 cycle, then `usb_rd_n`=0 for 3 cycles.
  - `usb_ad_out` reads 0x1111, 0x2222, 0x3333 on consecutive cycles.
  - `usb_rxf` rises after the third pop.
  - `err_underrun` stays 0.
- Read past empty: a 4th cycle of `usb_rd_n`=0 after the test above → `err_underrun`=1, no pointer movement, `usb_ad_out` unchanged.
- Write to full: hold `usb_wr_n`=0 for 17 cycles with data 0..16.
  - `usb_txe` goes 1 after the 16th accept.
  - Word 16 is dropped and `err_overrun`=1.
  - Popping yields 0..15 in order.
- Full-FIFO flow-through: with the TX FIFO full, do a local pop and a bus write on the same edge → count stays 16, and the new word lands at the tail.
- Contention: `usb_wr_n`=0 and `usb_oe_n`=0 together → `err_contention`=1 and the TX count is unchanged.
- Reset mid-burst: assert `RST` during a read stream.
  - Next cycle: `usb_rxf`=1, `usb_txe`=1, `usb_ad_oe`=0 and all errors cleared.
  - After release: `usb_txe`=0 after 1 cycle.
